mem_arbiter: RTL and testbench

Two-requester arbiter sharing the single-ported unified core memory between the instruction-fetch unit and the load/store unit. Each cycle it grants at most one request, drives the memory command combinationally, and routes the one-cycle-later read data back to the owning requester. Data accesses have priority by default. A starvation counter forces a fetch grant after a bounded wait. It sits between the core pipeline and the memory block.

---
 rtl/mem_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported core memory between the instruction-fetch
// unit (IF) and the load/store unit (LS).
//
// Each cycle at most one request is granted. The memory command is driven
// combinationally from the winner, and the read data that comes back one cycle later
// is sent to whichever requester owned that access. LS wins by default. A starvation
// counter forces an IF grant after MAX_STALL consecutive denied fetch cycles.
//
// Parameters:
//   DATA_WIDTH  data word width; byte-mask width is DATA_WIDTH/8
//   ADDR_WIDTH  byte address width
//   MAX_STALL   denied fetch cycles before fetch is forced to win (1..15)
//
// Ports:
//   clk, arst_n                    clock (rising edge), async active-low reset
//   if_req_valid/if_req_ready      fetch request handshake; if_addr is the payload
//   if_rsp_valid/if_rsp_data       fetch read data, one cycle after accept
//   ls_req_valid/ls_req_ready      load/store request handshake
//   ls_we, ls_mask, ls_addr,
//   ls_wdata                       load/store payload
//   ls_rsp_valid/ls_rsp_data       load data or store acknowledge (data 0)
//   mem_en, mem_we, mem_mask,
//   mem_addr, mem_wdata            memory command (all zero when idle)
//   mem_rdata                      memory read data, valid the cycle after mem_en
//   conflict_cnt                   wrapping count of cycles with both requests valid

module mem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned MAX_STALL  = 4
) (
  input  logic                    clk,
  input  logic                    arst_n,

  // Instruction fetch port
  input  logic                    if_req_valid,
  output logic                    if_req_ready,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_rsp_valid,
  output logic [DATA_WIDTH-1:0]   if_rsp_data,

  // Load/store port
  input  logic                    ls_req_valid,
  output logic                    ls_req_ready,
  input  logic                    ls_we,
  input  logic [DATA_WIDTH/8-1:0] ls_mask,
  input  logic [ADDR_WIDTH-1:0]   ls_addr,
  input  logic [DATA_WIDTH-1:0]   ls_wdata,
  output logic                    ls_rsp_valid,
  output logic [DATA_WIDTH-1:0]   ls_rsp_data,

  // Memory port
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [DATA_WIDTH/8-1:0] mem_mask,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,

  // Statistics
  output logic [31:0]             conflict_cnt
);

  localparam logic [3:0] MaxStall = 4'(MAX_STALL);

  // Owner of the access issued in the previous cycle.
  typedef enum logic [1:0] {
    SelNone = 2'd0,
    SelIf   = 2'd1,
    SelLs   = 2'd2
  } rsp_sel_e;

  rsp_sel_e    rsp_sel_q, rsp_sel_d;
  logic        rsp_is_wr_q, rsp_is_wr_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0] conflict_cnt_q, conflict_cnt_d;

  logic force_if;
  logic grant_if;
  logic grant_ls;
  logic both_valid;

  // ---------------------------------------------------------------------------
  // Grant logic
  // ---------------------------------------------------------------------------
  assign force_if   = (starve_cnt_q == MaxStall);
  assign both_valid = if_req_valid && ls_req_valid;

  // arst_n gates the grants directly so they drop the instant reset asserts,
  // without waiting for a clock edge.
  assign grant_ls = arst_n && ls_req_valid && !force_if;
  assign grant_if = arst_n && if_req_valid && (!ls_req_valid || force_if);

  assign if_req_ready = grant_if;
  assign ls_req_ready = grant_ls;

  // ---------------------------------------------------------------------------
  // Memory command mux
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_mask  = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (grant_ls) begin
      mem_en    = 1'b1;
      mem_we    = ls_we;
      // Reads never carry byte enables, whatever the requester left on ls_mask.
      mem_mask  = ls_we ? ls_mask : '0;
      mem_addr  = ls_addr;
      mem_wdata = ls_wdata;
    end else if (grant_if) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!if_req_valid || grant_if) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != MaxStall) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_comb begin
    rsp_sel_d   = SelNone;
    rsp_is_wr_d = 1'b0;
    if (grant_ls) begin
      rsp_sel_d   = SelLs;
      rsp_is_wr_d = ls_we;
    end else if (grant_if) begin
      rsp_sel_d   = SelIf;
    end
  end

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (both_valid) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rsp_sel_q      <= SelNone;
      rsp_is_wr_q    <= 1'b0;
      starve_cnt_q   <= 4'd0;
      conflict_cnt_q <= 32'd0;
    end else begin
      rsp_sel_q      <= rsp_sel_d;
      rsp_is_wr_q    <= rsp_is_wr_d;
      starve_cnt_q   <= starve_cnt_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------------
  always_comb begin
    if_rsp_valid = 1'b0;
    if_rsp_data  = '0;
    ls_rsp_valid = 1'b0;
    ls_rsp_data  = '0;
    unique case (rsp_sel_q)
      SelIf: begin
        if_rsp_valid = 1'b1;
        if_rsp_data  = mem_rdata;
      end
      SelLs: begin
        ls_rsp_valid = 1'b1;
        // Store acknowledges return zero rather than whatever the memory drives.
        ls_rsp_data  = rsp_is_wr_q ? '0 : mem_rdata;
      end
      default: ;
    endcase
  end

  assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        arst_n;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [31:0] if_addr;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid;
  logic        ls_req_ready;
  logic        ls_we;
  logic [3:0]  ls_mask;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;
  logic        mem_en;
  logic        mem_we;
  logic [3:0]  mem_mask;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic [31:0] conflict_cnt;

  mem_arbiter #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .MAX_STALL  (4)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_addr      (if_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .ls_req_valid (ls_req_valid),
    .ls_req_ready (ls_req_ready),
    .ls_we        (ls_we),
    .ls_mask      (ls_mask),
    .ls_addr      (ls_addr),
    .ls_wdata     (ls_wdata),
    .ls_rsp_valid (ls_rsp_valid),
    .ls_rsp_data  (ls_rsp_data),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_mask     (mem_mask),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Bench-side model state for the multi-cycle sequences.
  logic        prev_if;
  logic        prev_ls;
  logic [31:0] conf_model;
  int          cyc;

  typedef struct {
    logic        if_v;
    logic [31:0] if_a;
    logic        ls_v;
    logic        we;
    logic [3:0]  mask;
    logic [31:0] ls_a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        e_ifr;
    logic        e_lsr;
    logic        e_en;
    logic        e_we;
    logic [3:0]  e_mask;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic        e_ifv;
    logic [31:0] e_ifd;
    logic        e_lsv;
    logic [31:0] e_lsd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of IF/LS loads; checks grants, routed responses and conflict_cnt.
  task automatic contend(input logic if_v, input logic ls_v, input logic exp_if,
                         input string tag);
    logic exp_ls;
    logic [31:0] rd;
    exp_ls       = ls_v && !exp_if;
    rd           = 32'hC0DE_0000 | 32'(cyc);
    if_req_valid = if_v;
    if_addr      = 32'h0000_1000 + 32'(cyc);
    ls_req_valid = ls_v;
    ls_we        = 1'b0;
    ls_mask      = 4'h0;
    ls_addr      = 32'h0000_2000 + 32'(cyc);
    ls_wdata     = 32'h0;
    mem_rdata    = rd;
    @(negedge clk);
    chk({tag, " if_req_ready"}, {31'b0, if_req_ready}, {31'b0, exp_if});
    chk({tag, " ls_req_ready"}, {31'b0, ls_req_ready}, {31'b0, exp_ls});
    chk({tag, " if_rsp_valid"}, {31'b0, if_rsp_valid}, {31'b0, prev_if});
    chk({tag, " if_rsp_data"}, if_rsp_data, prev_if ? rd : 32'h0);
    chk({tag, " ls_rsp_valid"}, {31'b0, ls_rsp_valid}, {31'b0, prev_ls});
    chk({tag, " ls_rsp_data"}, ls_rsp_data, prev_ls ? rd : 32'h0);
    chk({tag, " conflict_cnt"}, conflict_cnt, conf_model);
    @(posedge clk);
    #1;
    if (if_v && ls_v) conf_model++;
    prev_if = exp_if;
    prev_ls = exp_ls;
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        if_v if_a          ls_v we mask   ls_a          wd            rd
    //        ifr lsr en we mask addr wd | ifv ifd | lsv lsd
    vecs[0] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0000_0055,
                1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                1'b0, 32'h0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 32'h8000_0010, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0000_0066,
                1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h8000_0010, 32'h0,
                1'b0, 32'h0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0000_0013,
                1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                1'b1, 32'h0000_0013, 1'b0, 32'h0};
    // Idle with junk payload present: the memory command must stay all-zero.
    vecs[3] = '{1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'hF, 32'h1234_5678, 32'hCAFE_F00D,
                32'h0000_0099,
                1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                1'b0, 32'h0, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF,
                32'h0000_0077,
                1'b0, 1'b1, 1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF,
                1'b0, 32'h0, 1'b0, 32'h0};
    // Load carries a stale mask; the memory must see all-zero enables.
    vecs[5] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h0, 32'h1234_5678,
                1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0000_0100, 32'h0,
                1'b0, 32'h0, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0000_BEEF,
                1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                1'b0, 32'h0, 1'b1, 32'h0000_BEEF};
    vecs[7] = '{1'b1, 32'h0000_0040, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0000_0088,
                1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h0000_0040, 32'h0,
                1'b0, 32'h0, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_0200, 32'h0, 32'hAAAA_0001,
                1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 32'h0000_0200, 32'h0,
                1'b1, 32'hAAAA_0001, 1'b0, 32'h0};
    vecs[9] = '{1'b0, 32'h0, 1'b0, 1'b1, 4'hF, 32'h0, 32'h5555_5555, 32'hBBBB_0002,
                1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0,
                1'b0, 32'h0, 1'b1, 32'hBBBB_0002};

    // Reset with both requests asserted: nothing may be granted.
    arst_n       = 1'b0;
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    if_addr      = 32'h0;
    ls_we        = 1'b0;
    ls_mask      = 4'h0;
    ls_addr      = 32'h0;
    ls_wdata     = 32'h0;
    mem_rdata    = 32'hFFFF_FFFF;
    prev_if      = 1'b0;
    prev_ls      = 1'b0;
    conf_model   = 32'h0;
    cyc          = 0;
    #12;
    chk("reset if_req_ready", {31'b0, if_req_ready}, 32'h0);
    chk("reset ls_req_ready", {31'b0, ls_req_ready}, 32'h0);
    chk("reset mem_en", {31'b0, mem_en}, 32'h0);
    chk("reset if_rsp_data", if_rsp_data, 32'h0);
    chk("reset ls_rsp_data", ls_rsp_data, 32'h0);
    chk("reset conflict_cnt", conflict_cnt, 32'h0);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    arst_n       = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle mem_en", {31'b0, mem_en}, 32'h0);
      chk("idle if_rsp_valid", {31'b0, if_rsp_valid}, 32'h0);
      chk("idle ls_rsp_valid", {31'b0, ls_rsp_valid}, 32'h0);
      chk("idle conflict_cnt", conflict_cnt, 32'h0);
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < 10; i++) begin
      if_req_valid = vecs[i].if_v;
      if_addr      = vecs[i].if_a;
      ls_req_valid = vecs[i].ls_v;
      ls_we        = vecs[i].we;
      ls_mask      = vecs[i].mask;
      ls_addr      = vecs[i].ls_a;
      ls_wdata     = vecs[i].wd;
      mem_rdata    = vecs[i].rd;
      @(negedge clk);
      chk($sformatf("vec%0d if_req_ready", i), {31'b0, if_req_ready}, {31'b0, vecs[i].e_ifr});
      chk($sformatf("vec%0d ls_req_ready", i), {31'b0, ls_req_ready}, {31'b0, vecs[i].e_lsr});
      chk($sformatf("vec%0d mem_en", i), {31'b0, mem_en}, {31'b0, vecs[i].e_en});
      chk($sformatf("vec%0d mem_we", i), {31'b0, mem_we}, {31'b0, vecs[i].e_we});
      chk($sformatf("vec%0d mem_mask", i), {28'b0, mem_mask}, {28'b0, vecs[i].e_mask});
      chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d mem_wdata", i), mem_wdata, vecs[i].e_wd);
      chk($sformatf("vec%0d if_rsp_valid", i), {31'b0, if_rsp_valid}, {31'b0, vecs[i].e_ifv});
      chk($sformatf("vec%0d if_rsp_data", i), if_rsp_data, vecs[i].e_ifd);
      chk($sformatf("vec%0d ls_rsp_valid", i), {31'b0, ls_rsp_valid}, {31'b0, vecs[i].e_lsv});
      chk($sformatf("vec%0d ls_rsp_data", i), ls_rsp_data, vecs[i].e_lsd);
      @(posedge clk);
      #1;
    end

    // Continuous contention: LS,LS,LS,LS,IF repeating.
    prev_if = 1'b0;
    prev_ls = 1'b0;
    for (int k = 0; k < 15; k++) begin
      contend(1'b1, 1'b1, (k % 5) == 4, $sformatf("contend%0d", k));
    end

    // IF drops while starving: the counter restarts from zero.
    contend(1'b1, 1'b1, 1'b0, "drop_a");
    contend(1'b1, 1'b1, 1'b0, "drop_b");
    contend(1'b0, 1'b1, 1'b0, "drop_gap");
    for (int k = 0; k < 5; k++) begin
      contend(1'b1, 1'b1, k == 4, $sformatf("after_drop%0d", k));
    end

    // Reset in the cycle after a load grant, with starve_cnt part-way up.
    contend(1'b1, 1'b1, 1'b0, "pre_rst_a");
    contend(1'b1, 1'b1, 1'b0, "pre_rst_b");
    contend(1'b1, 1'b1, 1'b0, "pre_rst_c");
    arst_n = 1'b0;
    #1;
    chk("midrst ls_rsp_valid", {31'b0, ls_rsp_valid}, 32'h0);
    chk("midrst ls_rsp_data", ls_rsp_data, 32'h0);
    chk("midrst if_req_ready", {31'b0, if_req_ready}, 32'h0);
    chk("midrst ls_req_ready", {31'b0, ls_req_ready}, 32'h0);
    chk("midrst mem_en", {31'b0, mem_en}, 32'h0);
    chk("midrst conflict_cnt", conflict_cnt, 32'h0);
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    @(posedge clk);
    #1;
    arst_n     = 1'b1;
    prev_if    = 1'b0;
    prev_ls    = 1'b0;
    conf_model = 32'h0;
    contend(1'b0, 1'b0, 1'b0, "post_rst_idle");
    for (int k = 0; k < 5; k++) begin
      contend(1'b1, 1'b1, k == 4, $sformatf("post_rst%0d", k));
    end
    contend(1'b0, 1'b0, 1'b0, "final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
